// File: rtl/mp_pkg.sv
// Shared definitions for the multiplier processor: front-end FSM state encoding,
// opcode constants and instruction field positions. Also used by result-select
// and write-back logic downstream.
package mp_pkg;

    // Front-end sequencing states, one per cycle of the fetch/read/issue flow
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_OP_READ  = 4'd1,
        ST_OP_WAIT  = 4'd2,
        ST_RA_READ  = 4'd3,
        ST_RB_READ  = 4'd4,
        ST_OP_WAIT2 = 4'd5,
        ST_ISSUE    = 4'd6,
        ST_FINISH   = 4'd7
    } mp_state_e;

    // Opcode 0 is a no-operation; bit 3 selects the multiplier over the ALU
    localparam logic [3:0] OPC_NOP     = 4'b0000;
    localparam int         OPC_MUL_BIT = 3;

    // Instruction word layout: [15:12] opcode, [11:8] Rd, [7:4] Ra, [3:0] Rb
    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;

    // True when the opcode routes to the multiplier rather than the ALU
    function automatic logic opc_is_mul(input logic [3:0] opc);
        return opc[OPC_MUL_BIT];
    endfunction

endpackage

// File: rtl/mp_instr_decode.sv
// Combinational split of an instruction word into its fields plus a NOP flag.
module mp_instr_decode
    import mp_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [3:0]         rd,
    output logic [3:0]         ra,
    output logic [3:0]         rb,
    output logic               is_nop
);

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign ra     = instr[RA_MSB:RA_LSB];
    assign rb     = instr[RB_MSB:RB_LSB];
    assign is_nop = (instr[OPC_MSB:OPC_LSB] == OPC_NOP);

endmodule

// File: rtl/mp_operand_fetch.sv
// Multiplier processor front end: walks the program once per start pulse,
// fetching each word, reading Ra then Rb from the register file, and holding
// the issue bundle until execute accepts it. All outputs come from flops.
module mp_operand_fetch
    import mp_pkg::*;
#(
    parameter int N_INSTR = 16,
    parameter int IADDR_W = 4,
    parameter int DATA_W  = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               imem_re,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               rf_re,
    output logic [3:0]         rf_raddr,
    input  logic [DATA_W-1:0]  rf_rdata,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [3:0]         iss_opcode,
    output logic [3:0]         iss_rd,
    output logic [DATA_W-1:0]  iss_opa,
    output logic [DATA_W-1:0]  iss_opb,
    output logic               busy,
    output logic               done
);

    localparam logic [IADDR_W-1:0] LAST_PC = IADDR_W'(N_INSTR - 1);
    localparam logic [IADDR_W-1:0] PC_ONE  = IADDR_W'(1);

    mp_state_e            state_q, state_d;
    logic [IADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]    opa_q, opa_d;
    logic [DATA_W-1:0]    opb_q, opb_d;

    logic                 imem_re_q, imem_re_d;
    logic [IADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic                 rf_re_q, rf_re_d;
    logic [3:0]           rf_raddr_q, rf_raddr_d;
    logic                 iss_valid_q, iss_valid_d;
    logic [3:0]           iss_opcode_q, iss_opcode_d;
    logic [3:0]           iss_rd_q, iss_rd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [3:0]           dec_opcode_s;
    logic [3:0]           dec_rd_s;
    logic [3:0]           dec_ra_s;
    logic [3:0]           dec_rb_s;
    logic                 dec_is_nop_s;

    // The instruction register captures the memory word only in the cycle it is valid
    assign instr_d = (state_q == ST_OP_WAIT) ? imem_rdata : instr_q;

    // Decoding the next-instruction value lets the NOP branch and Ra/Rb address
    // selection act on a word in the same cycle it arrives from memory
    mp_instr_decode u_decode (
        .instr  (instr_d),
        .opcode (dec_opcode_s),
        .rd     (dec_rd_s),
        .ra     (dec_ra_s),
        .rb     (dec_rb_s),
        .is_nop (dec_is_nop_s)
    );

    // Next-state, pc and operand capture logic for the fetch/read/issue sequence
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_OP_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OP_READ: begin
                state_d = ST_OP_WAIT;
            end
            ST_OP_WAIT: begin
                if (dec_is_nop_s) begin
                    opa_d   = {DATA_W{1'b0}};
                    opb_d   = {DATA_W{1'b0}};
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_RA_READ;
                end
            end
            ST_RA_READ: begin
                state_d = ST_RB_READ;
            end
            ST_RB_READ: begin
                opa_d   = rf_rdata;
                state_d = ST_OP_WAIT2;
            end
            ST_OP_WAIT2: begin
                opb_d   = rf_rdata;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (iss_ready) begin
                    if (pc_q == LAST_PC) begin
                        state_d = ST_FINISH;
                    end else begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = ST_OP_READ;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                pc_d    = {IADDR_W{1'b0}};
                state_d = ST_IDLE;
            end
            default: begin
                pc_d    = {IADDR_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered
    always_comb begin
        imem_re_d    = (state_d == ST_OP_READ);
        imem_addr_d  = {IADDR_W{1'b0}};
        rf_re_d      = (state_d == ST_RA_READ) || (state_d == ST_RB_READ);
        rf_raddr_d   = 4'd0;
        iss_valid_d  = (state_d == ST_ISSUE);
        iss_opcode_d = dec_opcode_s;
        iss_rd_d     = dec_rd_s;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_FINISH);
        if (imem_re_d) begin
            imem_addr_d = pc_d;
        end else begin
            imem_addr_d = {IADDR_W{1'b0}};
        end
        if (state_d == ST_RA_READ) begin
            rf_raddr_d = dec_ra_s;
        end else if (state_d == ST_RB_READ) begin
            rf_raddr_d = dec_rb_s;
        end else begin
            rf_raddr_d = 4'd0;
        end
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= {IADDR_W{1'b0}};
            instr_q      <= {INSTR_W{1'b0}};
            opa_q        <= {DATA_W{1'b0}};
            opb_q        <= {DATA_W{1'b0}};
            imem_re_q    <= 1'b0;
            imem_addr_q  <= {IADDR_W{1'b0}};
            rf_re_q      <= 1'b0;
            rf_raddr_q   <= 4'd0;
            iss_valid_q  <= 1'b0;
            iss_opcode_q <= 4'd0;
            iss_rd_q     <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            imem_re_q    <= imem_re_d;
            imem_addr_q  <= imem_addr_d;
            rf_re_q      <= rf_re_d;
            rf_raddr_q   <= rf_raddr_d;
            iss_valid_q  <= iss_valid_d;
            iss_opcode_q <= iss_opcode_d;
            iss_rd_q     <= iss_rd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign imem_re    = imem_re_q;
    assign imem_addr  = imem_addr_q;
    assign rf_re      = rf_re_q;
    assign rf_raddr   = rf_raddr_q;
    assign iss_valid  = iss_valid_q;
    assign iss_opcode = iss_opcode_q;
    assign iss_rd     = iss_rd_q;
    assign iss_opa    = opa_q;
    assign iss_opb    = opb_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mp_operand_fetch.sv
// Directed bench for mp_operand_fetch: a 16-instruction instance driven from a
// vector table and a 1-instruction instance for the single-op run.
module tb_mp_operand_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Instance A: N_INSTR=16
    logic        start_a, imem_re_a, rf_re_a, iss_valid_a, iss_ready_a, busy_a, done_a;
    logic [3:0]  imem_addr_a, rf_raddr_a, iss_opcode_a, iss_rd_a;
    logic [15:0] imem_rdata_a;
    logic [63:0] rf_rdata_a, iss_opa_a, iss_opb_a;

    // Instance B: N_INSTR=1
    logic        start_b, imem_re_b, rf_re_b, iss_valid_b, iss_ready_b, busy_b, done_b;
    logic [3:0]  imem_addr_b, rf_raddr_b, iss_opcode_b, iss_rd_b;
    logic [15:0] imem_rdata_b;
    logic [63:0] rf_rdata_b, iss_opa_b, iss_opb_b;

    logic [15:0] imem_a [16];
    logic [15:0] imem_b [16];
    logic [63:0] rf     [16];

    mp_operand_fetch #(.N_INSTR(16), .IADDR_W(4), .DATA_W(64)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .imem_re(imem_re_a), .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a),
        .rf_re(rf_re_a), .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a),
        .iss_valid(iss_valid_a), .iss_ready(iss_ready_a), .iss_opcode(iss_opcode_a),
        .iss_rd(iss_rd_a), .iss_opa(iss_opa_a), .iss_opb(iss_opb_a),
        .busy(busy_a), .done(done_a)
    );

    mp_operand_fetch #(.N_INSTR(1), .IADDR_W(4), .DATA_W(64)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .imem_re(imem_re_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .rf_re(rf_re_b), .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
        .iss_valid(iss_valid_b), .iss_ready(iss_ready_b), .iss_opcode(iss_opcode_b),
        .iss_rd(iss_rd_b), .iss_opa(iss_opa_b), .iss_opb(iss_opb_b),
        .busy(busy_b), .done(done_b)
    );

    // Synchronous-read memory models: data appears the cycle after the enable
    always @(posedge clk) begin
        if (imem_re_a) imem_rdata_a <= imem_a[imem_addr_a];
        if (rf_re_a)   rf_rdata_a   <= rf[rf_raddr_a];
        if (imem_re_b) imem_rdata_b <= imem_b[imem_addr_b];
        if (rf_re_b)   rf_rdata_b   <= rf[rf_raddr_b];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic [63:0] opa;
        logic [63:0] opb;
        int          lat;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int t_fetch, t_valid, dones, acc_idx, fetch_idx, rf_reads, addr_bad, hold;
        int last_addr, rf_cnt, hit, found;
        bit seen_valid;

        // rf[i] = i replicated in every nibble, so operands are easy to read
        tbl[0]  = '{16'h8123, 4'h8, 4'h1, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 5};
        tbl[1]  = '{16'h1456, 4'h1, 4'h4, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666, 5};
        tbl[2]  = '{16'h0000, 4'h0, 4'h0, 64'h0,                   64'h0,                   2};
        tbl[3]  = '{16'h9777, 4'h9, 4'h7, 64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777, 5};
        tbl[4]  = '{16'h2F0E, 4'h2, 4'hF, 64'h0,                   64'hEEEE_EEEE_EEEE_EEEE, 5};
        tbl[5]  = '{16'hA89A, 4'hA, 4'h8, 64'h9999_9999_9999_9999, 64'hAAAA_AAAA_AAAA_AAAA, 5};
        tbl[6]  = '{16'h3BCD, 4'h3, 4'hB, 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD, 5};
        tbl[7]  = '{16'hB210, 4'hB, 4'h2, 64'h1111_1111_1111_1111, 64'h0,                   5};
        tbl[8]  = '{16'h0F12, 4'h0, 4'hF, 64'h0,                   64'h0,                   2};
        tbl[9]  = '{16'hC345, 4'hC, 4'h3, 64'h4444_4444_4444_4444, 64'h5555_5555_5555_5555, 5};
        tbl[10] = '{16'h4567, 4'h4, 4'h5, 64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777, 5};
        tbl[11] = '{16'hD6FF, 4'hD, 4'h6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5};
        tbl[12] = '{16'h5789, 4'h5, 4'h7, 64'h8888_8888_8888_8888, 64'h9999_9999_9999_9999, 5};
        tbl[13] = '{16'hE8AB, 4'hE, 4'h8, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 5};
        tbl[14] = '{16'h6C3C, 4'h6, 4'hC, 64'h3333_3333_3333_3333, 64'hCCCC_CCCC_CCCC_CCCC, 5};
        tbl[15] = '{16'hFD01, 4'hF, 4'hD, 64'h0,                   64'h1111_1111_1111_1111, 5};

        for (int i = 0; i < 16; i++) begin
            imem_a[i] = tbl[i].instr;
            imem_b[i] = 16'h0000;
            rf[i]     = 64'h0;
        end

        // ---------------- Reset ----------------
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        iss_ready_a = 1'b0; iss_ready_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_iss_valid", 64'(iss_valid_a), 64'd0);
        chk("rst_busy",      64'(busy_a),      64'd0);
        chk("rst_done",      64'(done_a),      64'd0);
        chk("rst_imem_re",   64'(imem_re_a),   64'd0);
        chk("rst_rf_re",     64'(rf_re_a),     64'd0);
        chk("rst_opa",       iss_opa_a,        64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ---------------- Single op on N_INSTR=1 ----------------
        rf[1] = 64'd5; rf[2] = 64'd7;
        imem_b[0] = 16'h1312;
        iss_ready_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        t_fetch = -1; t_valid = -1; dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (imem_re_b && t_fetch < 0) t_fetch = c;
            if (iss_valid_b && t_valid < 0) begin
                t_valid = c;
                chk("single_opcode", 64'(iss_opcode_b), 64'h1);
                chk("single_rd",     64'(iss_rd_b),     64'h3);
                chk("single_opa",    iss_opa_b,         64'd5);
                chk("single_opb",    iss_opb_b,         64'd7);
            end
            if (done_b) dones++;
            @(negedge clk);
        end
        chk("single_fetch_cycle", 64'(t_fetch),           64'd0);
        chk("single_latency",     64'(t_valid - t_fetch), 64'd5);
        chk("single_done_count",  64'(dones),             64'd1);
        chk("single_idle_busy",   64'(busy_b),            64'd0);

        // ---------------- Full 16-instruction run with backpressure ----------------
        for (int i = 0; i < 16; i++) rf[i] = 64'h1111_1111_1111_1111 * 64'(i);
        iss_ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        acc_idx = 0; fetch_idx = 0; rf_reads = 0; addr_bad = 0; hold = 0;
        dones = 0; t_fetch = 0; seen_valid = 1'b0;
        for (int c = 0; c < 140; c++) begin
            if (imem_re_a) begin
                chk("fetch_addr", 64'(imem_addr_a), 64'(fetch_idx));
                fetch_idx++;
                t_fetch = c;
                seen_valid = 1'b0;
            end else if (imem_addr_a != 4'd0) begin
                addr_bad++;
            end
            if (rf_re_a) rf_reads++;
            else if (rf_raddr_a != 4'd0) addr_bad++;
            if (done_a) dones++;
            // start while busy must be ignored
            start_a = (c == 40) ? 1'b1 : 1'b0;
            if (iss_valid_a && acc_idx < 16) begin
                if (!seen_valid) begin
                    chk("issue_latency", 64'(c - t_fetch), 64'(tbl[acc_idx].lat));
                    seen_valid = 1'b1;
                end
                chk("bundle_opcode", 64'(iss_opcode_a), 64'(tbl[acc_idx].opc));
                chk("bundle_rd",     64'(iss_rd_a),     64'(tbl[acc_idx].rd));
                chk("bundle_opa",    iss_opa_a,         tbl[acc_idx].opa);
                chk("bundle_opb",    iss_opb_a,         tbl[acc_idx].opb);
                if (acc_idx == 1 && hold < 4) begin
                    iss_ready_a = 1'b0;
                    hold++;
                end else begin
                    iss_ready_a = 1'b1;
                    acc_idx++;
                end
            end else begin
                iss_ready_a = 1'b1;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        chk("run_accepts",     64'(acc_idx),   64'd16);
        chk("run_fetches",     64'(fetch_idx), 64'd16);
        chk("run_done_count",  64'(dones),     64'd1);
        chk("run_rf_reads",    64'(rf_reads),  64'd28);
        chk("run_idle_addr",   64'(addr_bad),  64'd0);
        chk("run_hold_cycles", 64'(hold),      64'd4);
        chk("run_end_busy",    64'(busy_a),    64'd0);

        // ---------------- Reset during RB_READ of pc=5 ----------------
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        last_addr = -1; rf_cnt = 0; hit = 0; dones = 0;
        for (int c = 0; c < 100 && hit == 0; c++) begin
            if (imem_re_a) begin
                last_addr = int'(imem_addr_a);
                rf_cnt = 0;
            end
            if (rf_re_a) rf_cnt++;
            if (done_a) dones++;
            if (last_addr == 5 && rf_cnt == 2) begin
                reset_n = 1'b0;
                hit = 1;
            end
            @(negedge clk);
        end
        chk("midrst_reached",   64'(hit),         64'd1);
        chk("midrst_iss_valid", 64'(iss_valid_a), 64'd0);
        chk("midrst_busy",      64'(busy_a),      64'd0);
        chk("midrst_rf_re",     64'(rf_re_a),     64'd0);
        chk("midrst_done",      64'(done_a),      64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        if (done_a) dones++;
        chk("midrst_no_done", 64'(dones), 64'd0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            if (imem_re_a) begin
                found = 1;
                chk("restart_addr", 64'(imem_addr_a), 64'd0);
            end else begin
                @(negedge clk);
            end
        end
        chk("restart_fetch_seen", 64'(found), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
